// File: rtl/eth_phy_10g_pkg.sv
// Shared constants for the 10GBASE-R RX PCS blocks.
package eth_phy_10g_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  // Wide enough for a 125 us window at 6.4 ns (19531) with headroom.
  localparam int WIN_TMR_W = 15;

  // A sync header is valid only when it is one of the two legal codes.
  function automatic logic hdr_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_window_timer.sv
// Reloadable down-counter: counts COUNT..0 and strobes expire while at 0,
// reloading on the following edge, so one window is COUNT+1 cycles.
module eth_phy_10g_rx_window_timer
  import eth_phy_10g_pkg::*;
#(
  parameter int COUNT = 19531
) (
  input  logic clk,
  input  logic rst,
  output logic expire
);

  localparam logic [WIN_TMR_W-1:0] RELOAD = WIN_TMR_W'(COUNT);

  logic [WIN_TMR_W-1:0] cnt;

  // Down-count, reload after the zero cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             cnt <= RELOAD;
    else if (cnt == '0)   cnt <= RELOAD;
    else                  cnt <= cnt - WIN_TMR_W'(1);
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/eth_phy_10g_rx_link_mon.sv
// 10GBASE-R RX link monitor: block lock with bitslip, BER monitor and
// link watchdog, all driven from the 66b sync headers and decoder errors.
module eth_phy_10g_rx_link_mon
  import eth_phy_10g_pkg::*;
#(
  parameter int HDR_WIDTH           = 2,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int COUNT_125US         = 19531
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
  input  logic                 rx_bad_block,
  input  logic                 rx_sequence_error,
  output logic                 serdes_rx_bitslip,
  output logic                 serdes_rx_reset_req,
  output logic                 rx_block_lock,
  output logic                 rx_high_ber,
  output logic                 rx_status
);

  if (HDR_WIDTH != 2) begin : g_hdr_width_chk
    $error("eth_phy_10g_rx_link_mon: HDR_WIDTH must be 2");
  end
  if (BITSLIP_HIGH_CYCLES < 1) begin : g_slip_high_chk
    $error("eth_phy_10g_rx_link_mon: BITSLIP_HIGH_CYCLES must be >= 1");
  end

  // A slip occupies HIGH+LOW cycles during which headers are ignored.
  localparam int                SLIP_TOTAL = BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES;
  localparam int                SLIP_W     = $clog2(SLIP_TOTAL + 1);
  localparam logic [SLIP_W-1:0] SLIP_LOAD  = SLIP_W'(SLIP_TOTAL);
  localparam logic [SLIP_W-1:0] SLIP_LOW   = SLIP_W'(BITSLIP_LOW_CYCLES);

  logic hdr_ok, hdr_ctrl, blk_err_in;
  logic ber_expire, wd_expire;

  assign hdr_ok     = hdr_valid(serdes_rx_hdr);
  assign hdr_ctrl   = (serdes_rx_hdr == SYNC_CTRL);
  assign blk_err_in = rx_bad_block | rx_sequence_error;

  eth_phy_10g_rx_window_timer #(.COUNT(COUNT_125US)) u_ber_tmr (
    .clk    (clk),
    .rst    (rst),
    .expire (ber_expire)
  );

  eth_phy_10g_rx_window_timer #(.COUNT(COUNT_125US)) u_wd_tmr (
    .clk    (clk),
    .rst    (rst),
    .expire (wd_expire)
  );

  // ---------------------------------------------------------------- frame sync
  logic [5:0]        sh_cnt, sh_cnt_nxt;
  logic [3:0]        inv_cnt, inv_cnt_nxt;
  logic [SLIP_W-1:0] slip_cnt, slip_cnt_nxt;
  logic              lock_nxt, bitslip_nxt;

  // Lock search: 64-header blocks, slip on any miss while unlocked or on the
  // 16th miss of a block while locked; slip_cnt != 0 blanks header checking.
  always_comb begin
    sh_cnt_nxt   = sh_cnt;
    inv_cnt_nxt  = inv_cnt;
    slip_cnt_nxt = slip_cnt;
    lock_nxt     = rx_block_lock;
    bitslip_nxt  = 1'b0;
    if (slip_cnt != '0) begin
      slip_cnt_nxt = slip_cnt - SLIP_W'(1);
      bitslip_nxt  = (slip_cnt - SLIP_W'(1)) > SLIP_LOW;
    end else begin
      sh_cnt_nxt = sh_cnt + 6'd1;
      if (hdr_ok) begin
        if (sh_cnt == 6'd63) begin
          sh_cnt_nxt  = '0;
          inv_cnt_nxt = '0;
          if (inv_cnt == '0) lock_nxt = 1'b1;
        end
      end else begin
        inv_cnt_nxt = inv_cnt + 4'd1;
        if (!rx_block_lock || inv_cnt == 4'd15) begin
          lock_nxt     = 1'b0;
          sh_cnt_nxt   = '0;
          inv_cnt_nxt  = '0;
          slip_cnt_nxt = SLIP_LOAD;
          bitslip_nxt  = 1'b1;
        end else if (sh_cnt == 6'd63) begin
          sh_cnt_nxt  = '0;
          inv_cnt_nxt = '0;
        end
      end
    end
  end

  // Frame sync state and registered lock/bitslip outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_cnt            <= '0;
      inv_cnt           <= '0;
      slip_cnt          <= '0;
      rx_block_lock     <= 1'b0;
      serdes_rx_bitslip <= 1'b0;
    end else begin
      sh_cnt            <= sh_cnt_nxt;
      inv_cnt           <= inv_cnt_nxt;
      slip_cnt          <= slip_cnt_nxt;
      rx_block_lock     <= lock_nxt;
      serdes_rx_bitslip <= bitslip_nxt;
    end
  end

  // --------------------------------------------------------------- BER monitor
  logic [3:0] ber_cnt, ber_cnt_nxt;
  logic       high_ber_nxt;

  // Count every invalid header (slip or not); expiry wins over the increment
  // and only a saturated window keeps high_ber set.
  always_comb begin
    ber_cnt_nxt  = ber_cnt;
    high_ber_nxt = rx_high_ber;
    if (ber_expire) begin
      if (ber_cnt != 4'd15) high_ber_nxt = 1'b0;
      ber_cnt_nxt = '0;
    end else if (!hdr_ok) begin
      if (ber_cnt != 4'd15) ber_cnt_nxt  = ber_cnt + 4'd1;
      else                  high_ber_nxt = 1'b1;
    end
  end

  // BER state and registered high_ber.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ber_cnt     <= '0;
      rx_high_ber <= 1'b0;
    end else begin
      ber_cnt     <= ber_cnt_nxt;
      rx_high_ber <= high_ber_nxt;
    end
  end

  // ------------------------------------------------------------------ watchdog
  logic       saw_ctrl, saw_ctrl_nxt;
  logic [6:0] blk_err, blk_err_nxt;
  logic [3:0] err_cnt, err_cnt_nxt;
  logic [3:0] stat_cnt, stat_cnt_nxt;
  logic       reset_req_nxt, status_nxt;

  // Grade each window at expiry (events in the expiry cycle itself are not
  // accumulated); losing lock or high BER zeroes the health counters and
  // suppresses a reset request in that cycle.
  always_comb begin
    saw_ctrl_nxt  = saw_ctrl | hdr_ctrl;
    blk_err_nxt   = blk_err;
    err_cnt_nxt   = err_cnt;
    stat_cnt_nxt  = stat_cnt;
    reset_req_nxt = 1'b0;
    if (blk_err_in && blk_err != 7'd127) blk_err_nxt = blk_err + 7'd1;
    if (wd_expire) begin
      saw_ctrl_nxt = 1'b0;
      blk_err_nxt  = '0;
      if (!saw_ctrl || blk_err == 7'd127) begin
        err_cnt_nxt  = err_cnt + 4'd1;
        stat_cnt_nxt = '0;
      end else begin
        err_cnt_nxt = '0;
        if (stat_cnt != 4'd15) stat_cnt_nxt = stat_cnt + 4'd1;
      end
      if (err_cnt == 4'd15) begin
        err_cnt_nxt   = '0;
        reset_req_nxt = 1'b1;
      end
    end
    if (!rx_block_lock || rx_high_ber) begin
      stat_cnt_nxt  = '0;
      err_cnt_nxt   = '0;
      reset_req_nxt = 1'b0;
    end
    status_nxt = (stat_cnt == 4'd15) && rx_block_lock && !rx_high_ber;
  end

  // Watchdog state, reset request pulse and link status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      saw_ctrl            <= 1'b0;
      blk_err             <= '0;
      err_cnt             <= '0;
      stat_cnt            <= '0;
      serdes_rx_reset_req <= 1'b0;
      rx_status           <= 1'b0;
    end else begin
      saw_ctrl            <= saw_ctrl_nxt;
      blk_err             <= blk_err_nxt;
      err_cnt             <= err_cnt_nxt;
      stat_cnt            <= stat_cnt_nxt;
      serdes_rx_reset_req <= reset_req_nxt;
      rx_status           <= status_nxt;
    end
  end

endmodule

// File: tb/tb_eth_phy_10g_rx_link_mon.sv
// Bench for eth_phy_10g_rx_link_mon: directed scenarios with arithmetic
// expectations plus a random run against a timestamp-based reference model.
module tb_eth_phy_10g_rx_link_mon;

  localparam int CNT   = 100;   // main instance window = 101 cycles
  localparam int CNT_L = 200;   // long-window instance, lets blk_err reach 127
  localparam int H     = 1;
  localparam int L     = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] hdr = 2'b10;
  logic       bad_blk = 1'b0, seq_err = 1'b0;
  logic       bitslip, reset_req, lock, high_ber, status;
  logic       bitslip_l, reset_req_l, lock_l, high_ber_l, status_l;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  eth_phy_10g_rx_link_mon #(.HDR_WIDTH(2), .BITSLIP_HIGH_CYCLES(H),
    .BITSLIP_LOW_CYCLES(L), .COUNT_125US(CNT)) u_dut (
    .clk(clk), .rst(rst), .serdes_rx_hdr(hdr), .rx_bad_block(bad_blk),
    .rx_sequence_error(seq_err), .serdes_rx_bitslip(bitslip),
    .serdes_rx_reset_req(reset_req), .rx_block_lock(lock),
    .rx_high_ber(high_ber), .rx_status(status));

  eth_phy_10g_rx_link_mon #(.HDR_WIDTH(2), .BITSLIP_HIGH_CYCLES(H),
    .BITSLIP_LOW_CYCLES(L), .COUNT_125US(CNT_L)) u_dut_l (
    .clk(clk), .rst(rst), .serdes_rx_hdr(hdr), .rx_bad_block(bad_blk),
    .rx_sequence_error(seq_err), .serdes_rx_bitslip(bitslip_l),
    .serdes_rx_reset_req(reset_req_l), .rx_block_lock(lock_l),
    .rx_high_ber(high_ber_l), .rx_status(status_l));

  // ------------------------------------------------------------ reference model
  // Time is the edge index since reset; windows end where idx mod (CNT+1)
  // equals CNT, a slip started at edge s blinds edges s+1..s+H+L.
  int m_cyc, m_blind, m_slip, m_sh, m_inv, m_ber, m_blk, m_err, m_stat;
  bit m_lock, m_hb, m_saw, m_bitslip, m_req, m_status;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cyc = 0; m_blind = -1; m_slip = -1000; m_sh = 0; m_inv = 0;
      m_ber = 0; m_blk = 0; m_err = 0; m_stat = 0;
      m_lock = 0; m_hb = 0; m_saw = 0; m_bitslip = 0; m_req = 0; m_status = 0;
    end else begin : step
      bit ok, p_lock, p_hb, expire;
      int p_stat;
      ok = (hdr == 2'b01) || (hdr == 2'b10);
      p_lock = m_lock; p_hb = m_hb; p_stat = m_stat;
      expire = (m_cyc % (CNT + 1)) == CNT;
      if (m_cyc > m_blind) begin
        m_sh++;
        if (!ok) m_inv++;
        if (ok && m_sh == 64) begin
          if (m_inv == 0) m_lock = 1;
          m_sh = 0; m_inv = 0;
        end else if (!ok) begin
          if (!p_lock || m_inv == 16) begin
            m_lock = 0; m_sh = 0; m_inv = 0; m_slip = m_cyc; m_blind = m_cyc + H + L;
          end else if (m_sh == 64) begin
            m_sh = 0; m_inv = 0;
          end
        end
      end
      m_bitslip = (m_cyc >= m_slip) && (m_cyc < m_slip + H);
      if (expire) begin
        if (m_ber < 15) m_hb = 0;
        m_ber = 0;
      end else if (!ok) begin
        if (m_ber < 15) m_ber++; else m_hb = 1;
      end
      m_req = 0;
      if (expire) begin
        m_req = (m_err == 15);
        if (!m_saw || m_blk >= 127) begin m_err++; m_stat = 0; end
        else begin m_err = 0; if (m_stat < 15) m_stat++; end
        if (m_req) m_err = 0;
        m_saw = 0; m_blk = 0;
      end else begin
        if (hdr == 2'b01) m_saw = 1;
        if (bad_blk || seq_err) m_blk++;
      end
      if (!p_lock || p_hb) begin m_stat = 0; m_err = 0; m_req = 0; end
      m_status = (p_stat == 15) && p_lock && !p_hb;
      m_cyc++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; hdr = 2'b10; bad_blk = 1'b0; seq_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    logic [9:0] got;
    @(negedge clk);
    rst = 1'b0; hdr = 2'b11;
    #1;
    got = {bitslip, reset_req, lock, high_ber, status,
           bitslip_l, reset_req_l, lock_l, high_ber_l, status_l};
    n_chk++;
    if (got !== 10'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0000000000", got);
    end
    @(negedge clk); rst = 1'b1;
    tick();
    n_chk++;
    if (bitslip !== 1'b1) begin
      n_fail++; $display("FAIL reset_slip_start: bitslip got %b expected 1", bitslip);
    end
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (bitslip !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_abort: bitslip got %b expected 0", bitslip);
    end
    @(negedge clk); rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if (bitslip !== 1'b0) begin
      n_fail++; $display("FAIL reset_slip_restart: bitslip got %b expected 0 one cycle after new slip", bitslip);
    end
  endtask

  task automatic test_lock_acquire();
    do_reset();
    for (int k = 0; k < 70; k++) begin
      tick();
      n_chk++;
      if (lock !== (k >= 63)) begin
        n_fail++; $display("FAIL lock_acquire: edge %0d lock got %b expected %b", k, lock, k >= 63);
      end
      n_chk++;
      if (bitslip !== 1'b0) begin
        n_fail++; $display("FAIL lock_no_slip: edge %0d bitslip got %b expected 0", k, bitslip);
      end
    end
  endtask

  task automatic test_slip_period();
    do_reset();
    hdr = 2'b11;
    for (int k = 0; k < 60; k++) begin
      tick();
      n_chk++;
      if (bitslip !== ((k % (H + L + 1)) < H)) begin
        n_fail++; $display("FAIL slip_period: edge %0d bitslip got %b expected %b", k, bitslip, (k % (H + L + 1)) < H);
      end
      n_chk++;
      if (lock !== 1'b0) begin
        n_fail++; $display("FAIL slip_no_lock: edge %0d lock got %b expected 0", k, lock);
      end
    end
  endtask

  task automatic test_lock_loss();
    int perm[64];
    bit inv_at[64];
    int last, slips;
    do_reset();
    repeat (64) tick();
    n_chk++;
    if (lock !== 1'b1) begin
      n_fail++; $display("FAIL loss_setup: lock got %b expected 1", lock);
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 64; i++) begin perm[i] = i; inv_at[i] = 0; end
      for (int i = 63; i > 0; i--) begin
        int j, t;
        j = $urandom_range(0, i); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < 15 + pass; i++) inv_at[perm[i]] = 1;
      last = 63;
      if (pass == 1) for (int i = 0; i < 64; i++) if (inv_at[i]) last = i;
      for (int k = 0; k <= last; k++) begin
        hdr = inv_at[k] ? 2'b11 : ((k % 2) ? 2'b10 : 2'b01);
        tick();
        n_chk++;
        if (lock !== !(pass == 1 && k == last)) begin
          n_fail++; $display("FAIL loss_lock_%0d: pos %0d lock got %b expected %b", 15 + pass, k, lock, !(pass == 1 && k == last));
        end
        n_chk++;
        if (bitslip !== (pass == 1 && k == last)) begin
          n_fail++; $display("FAIL loss_slip_%0d: pos %0d bitslip got %b expected %b", 15 + pass, k, bitslip, pass == 1 && k == last);
        end
      end
    end
    hdr = 2'b10;
    slips = 0;
    for (int k = 0; k < 20; k++) begin tick(); slips += int'(bitslip); end
    n_chk++;
    if (slips != 0 || lock !== 1'b0) begin
      n_fail++; $display("FAIL loss_single_slip: extra slips %0d lock %b expected 0 and 0", slips, lock);
    end
  endtask

  task automatic test_high_ber();
    bit exp;
    do_reset();
    for (int k = 0; k <= 310; k++) begin
      hdr = (k >= 110 && k < 126) ? 2'b11 : 2'b10;
      tick();
      exp = (k >= 125 && k < 302);
      n_chk++;
      if (high_ber !== exp) begin
        n_fail++; $display("FAIL high_ber: edge %0d got %b expected %b", k, high_ber, exp);
      end
    end
  endtask

  task automatic test_status();
    bit exp;
    do_reset();
    for (int k = 0; k <= 1620; k++) begin
      hdr = (k < 1515 && k % 8 == 0) ? 2'b01 : 2'b10;
      tick();
      exp = (k >= 15 * (CNT + 1) && k <= 16 * (CNT + 1) - 1);
      n_chk++;
      if (status !== exp) begin
        n_fail++; $display("FAIL status_ctrl: edge %0d got %b expected %b", k, status, exp);
      end
    end
  endtask

  task automatic test_status_blk_err();
    bit exp;
    int w16, w17;
    do_reset();
    w16 = 15 * (CNT_L + 1);
    w17 = 16 * (CNT_L + 1);
    for (int k = 0; k <= 3420; k++) begin
      hdr = (k % 8 == 0) ? 2'b01 : 2'b10;
      bad_blk = (k >= w16 && k < w16 + 126);
      seq_err = (k >= w16 && k < w16 + 126 && k % 2 == 0) || (k >= w17 && k < w17 + 127);
      tick();
      exp = (k >= w16 && k <= w17 + CNT_L);
      n_chk++;
      if (status_l !== exp) begin
        n_fail++; $display("FAIL status_blk_err: edge %0d got %b expected %b", k, status_l, exp);
      end
    end
    bad_blk = 1'b0; seq_err = 1'b0;
  endtask

  task automatic test_reset_req();
    bit exp;
    do_reset();
    for (int k = 0; k <= 3240; k++) begin
      tick();
      exp = (k == 16 * (CNT + 1) - 1) || (k == 32 * (CNT + 1) - 1);
      n_chk++;
      if (reset_req !== exp) begin
        n_fail++; $display("FAIL reset_req: edge %0d got %b expected %b", k, reset_req, exp);
      end
    end
  endtask

  task automatic test_random();
    int p_inv;
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      p_inv = ((k / 500) % 2) ? 25 : 1;
      if ($urandom_range(0, 99) < p_inv) hdr = $urandom_range(0, 1) ? 2'b11 : 2'b00;
      else hdr = ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b10;
      bad_blk = ($urandom_range(0, 19) == 0);
      seq_err = ($urandom_range(0, 19) == 0);
      if (k == 2000) rst = 1'b0;
      if (k == 2003) rst = 1'b1;
      tick();
      n_chk++;
      if ({bitslip, reset_req, lock, high_ber, status} !==
          {m_bitslip, m_req, m_lock, m_hb, m_status}) begin
        n_fail++;
        $display("FAIL random_model: step %0d slip/req/lock/ber/stat got %b%b%b%b%b expected %b%b%b%b%b",
                 k, bitslip, reset_req, lock, high_ber, status,
                 m_bitslip, m_req, m_lock, m_hb, m_status);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_slip_period();
    test_lock_loss();
    test_high_ber();
    test_status();
    test_status_blk_err();
    test_reset_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
